// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill of S, then the key-driven
// swap pass, driving a single-port registered S RAM under a start/done handshake.
module ksa_engine #(
  parameter int ADDR_W  = 8,
  parameter int KEY_LEN = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      init_en,
  input  logic [KEY_LEN*ADDR_W-1:0] key,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ADDR_W-1:0]         mem_wr_data,
  output logic                      mem_wren,
  input  logic [ADDR_W-1:0]         mem_rd_data
);
  localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {IDLE, INIT, RDI, LDI, RDJ, LDJ, WRI, WRJ, DONE} state_t;

  state_t                           state;
  logic [ADDR_W-1:0]                i, j, si;
  logic [KEY_LEN-1:0][ADDR_W-1:0]   key_r;
  logic [KW-1:0]                    kidx;
  logic [ADDR_W-1:0]                key_sel, j_nxt;

  // Entry 0 sits in the most-significant slice of the key bus.
  always_comb begin
    key_sel = key_r[KEY_LEN-1];
    for (int k = 0; k < KEY_LEN; k++)
      if (kidx == KW'(k)) key_sel = key_r[KEY_LEN-1-k];
  end

  assign j_nxt = j + mem_rd_data + key_sel;

  // Outputs are registered, so each transition loads the bus values of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wren    <= 1'b0;
      i           <= '0;
      j           <= '0;
      si          <= '0;
      key_r       <= '0;
      kidx        <= '0;
    end else begin
      done     <= 1'b0;
      mem_wren <= 1'b0;
      case (state)
        IDLE: if (start) begin
          key_r    <= key;
          i        <= '0;
          j        <= '0;
          kidx     <= '0;
          busy     <= 1'b1;
          mem_addr <= '0;
          if (init_en) begin
            state       <= INIT;
            mem_wr_data <= '0;
            mem_wren    <= 1'b1;
          end else begin
            state <= RDI;
          end
        end
        INIT: begin
          if (i == '1) begin
            i        <= '0;
            mem_addr <= '0;
            state    <= RDI;
          end else begin
            i           <= i + ADDR_W'(1);
            mem_addr    <= i + ADDR_W'(1);
            mem_wr_data <= i + ADDR_W'(1);
            mem_wren    <= 1'b1;
          end
        end
        RDI: state <= LDI;
        LDI: begin
          si       <= mem_rd_data;
          j        <= j_nxt;
          mem_addr <= j_nxt;
          state    <= RDJ;
        end
        RDJ: state <= LDJ;
        LDJ: begin
          mem_addr    <= i;
          mem_wr_data <= mem_rd_data;
          mem_wren    <= 1'b1;
          state       <= WRI;
        end
        // Writing j second means a j == i swap leaves si in place.
        WRI: begin
          mem_addr    <= j;
          mem_wr_data <= si;
          mem_wren    <= 1'b1;
          state       <= WRJ;
        end
        WRJ: begin
          kidx <= (kidx == KW'(KEY_LEN-1)) ? '0 : kidx + KW'(1);
          if (i == '1) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i        <= i + ADDR_W'(1);
            mem_addr <= i + ADDR_W'(1);
            state    <= RDI;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
